knight_action_ctrl: RTL and testbench
=====================================

Name: knight_action_ctrl

Overview:
- Frame-rate controller that sequences the knight movement datapath.
- Decodes the keyboard keycode plus ground and damage feedback into one action state.
- Emits per-frame signed X/Y velocity commands, sprite status and facing.
- The position datapath only integrates the velocities and clamps to screen/platform bounds; all jump, attack and hurt timing is decided here.

Parameters:
- WALK_SPEED, 2, X velocity magnitude while walking or air-steering (pixels/frame)
- RISE_SPEED, 6, upward Y velocity magnitude during jump rise
- FALL_SPEED, 6, downward Y velocity during fall/hurt-in-air
- KNOCK_SPEED, 3, X knockback magnitude during hurt
- MIN_JUMP, 4, minimum rise frames before key release can end a jump
- MAX_JUMP, 18, maximum rise frames
- ATK_FRAMES, 8, attack duration in frames
- ATK_COOLDOWN, 12, frames after attack end before next attack accepted
- HURT_FRAMES, 16, hurt stun duration
- INVULN_FRAMES, 40, frames (counted from hurt entry) during which hits are ignored

Ports:
- frame_clk  in  1  frame clock, one edge per video frame
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  current key: 0x50 left, 0x4F right, 0x52 jump, 0x1B attack, other = none
- on_ground  in  1  datapath: knight bottom resting on floor/platform this frame
- hit  in  1  collision logic: knight overlaps enemy this frame
- x_vel  out  10  signed two's-complement X velocity command
- y_vel  out  10  signed Y velocity command (negative = up)
- status  out  4  0 idle, 1 walk, 2 rise, 3 fall, 4 attack, 5 hurt
- facing  out  1  0 right, 1 left
- attack_active  out  1  high while in ATTACK (hitbox enable)
- invuln  out  1  high while invulnerability counter nonzero

Behaviour:
- Reset (async, Reset=1): state IDLE. x_vel=0, y_vel=0, status=0, facing=0, attack_active=0, invuln=0. All counters 0; prev_jump=0.
- All outputs registered. Inputs sampled at edge N give outputs at edge N; the datapath consumes them at edge N+1 (one-frame latency).
- prev_jump registers (keycode==0x52) every edge. jump_edge = key is 0x52 now and prev_jump=0.
- Priority each edge, highest first:
  - hit accepted: hit=1 and invuln counter=0
  - attack start
  - jump start
  - fall detect
  - walk/idle
- Hit accepted from any state:
  - enter HURT; hurt counter=HURT_FRAMES; invuln counter=INVULN_FRAMES.
  - x_vel = +KNOCK_SPEED if facing=1, else -KNOCK_SPEED. facing unchanged.
- IDLE/WALK:
  - key 0x1B with cooldown=0 -> ATTACK, counter=ATK_FRAMES, x_vel=0.
  - else jump_edge with on_ground=1 -> RISE, rise counter=0.
  - else on_ground=0 -> FALL.
  - else key 0x50/0x4F -> WALK, x_vel=∓WALK_SPEED, facing=1/0.
  - else IDLE, x_vel=0.
  - y_vel=0 in IDLE/WALK.
- RISE: y_vel=-RISE_SPEED; x_vel from left/right key (air steering, facing updates), else 0. Rise counter increments each frame. Go to FALL when:
  - counter reaches MAX_JUMP-1, or
  - key≠0x52 and counter≥MIN_JUMP-1.
  - Attack and hit still preempt.
- FALL: y_vel=+FALL_SPEED, air steering as in RISE. on_ground=1 -> IDLE, or WALK if a direction key is held (y_vel=0 same edge). Attack allowed in air; ATTACK then returns to FALL.
- ATTACK: attack_active=1, x_vel=0. y_vel=+FALL_SPEED if on_ground=0, else 0. Counter decrements. On reaching 0: cooldown=ATK_COOLDOWN, go to IDLE if on_ground else FALL. Keys other than hit are ignored.
- HURT: y_vel=FALL_SPEED if on_ground=0, else 0. Counter decrements; at 0, x_vel=0 and go to IDLE/FALL by on_ground. No key response.
- Cooldown and invuln counters decrement once per frame independently of state, saturating at 0. invuln = (invuln counter≠0).
- Simultaneous hit and attack key: hit wins, no attack, cooldown unchanged.
- Simultaneous jump_edge and attack key: attack wins; jump is lost (edge consumed).
- A hit arriving while invuln is high is ignored entirely.
- Held jump key never re-triggers a jump after landing; a new press is required.
- Counter widths: 6 bits minimum; parameters must be ≤63.

Test Plan:
- Reset asserted mid-RISE -> same cycle: status=0, x_vel=0, y_vel=0, facing=0; after release with keycode=0, stays IDLE.
- Grounded, keycode 0x4F for 3 frames then 0x50 -> status=1 with x_vel=+2, facing=0, then x_vel=-2 (0x3FE), facing=1.
- Jump held continuously, on_ground held 0 after press -> exactly 18 frames status=2 with y_vel=-6, then status=3 with y_vel=+6; on_ground=1 -> status=0, y_vel=0; no re-jump while 0x52 stays held.
- Tap jump for 1 frame -> exactly 4 rise frames, then FALL.
- Attack 0x1B held -> 8 frames attack_active=1, IDLE, no new attack for 12 frames, attack on frame 13.
- hit pulse with facing=0 -> status=5, x_vel=-3 for 16 frames, invuln high 40 frames; second hit at frame 20 ignored; hit at frame 41 accepted.

Source files
------------

// File: rtl/knight_action_if.sv
// Handshake bundle between the knight action controller and its surroundings:
// keyboard, ground and damage feedback in; velocity and sprite status out.
interface knight_action_if;
  logic [7:0] keycode;
  logic       on_ground;
  logic       hit;
  logic [9:0] x_vel;
  logic [9:0] y_vel;
  logic [3:0] status;
  logic       facing;
  logic       attack_active;
  logic       invuln;

  modport master (
    output keycode, on_ground, hit,
    input  x_vel, y_vel, status, facing, attack_active, invuln
  );

  modport slave (
    input  keycode, on_ground, hit,
    output x_vel, y_vel, status, facing, attack_active, invuln
  );
endinterface

// File: rtl/knight_action_ctrl.sv
// Frame-rate action sequencer for the knight: decodes keys, ground and hit
// feedback into one action state and registered per-frame velocity commands.
module knight_action_ctrl #(
  parameter int unsigned WALK_SPEED    = 2,
  parameter int unsigned RISE_SPEED    = 6,
  parameter int unsigned FALL_SPEED    = 6,
  parameter int unsigned KNOCK_SPEED   = 3,
  parameter int unsigned MIN_JUMP      = 4,
  parameter int unsigned MAX_JUMP      = 18,
  parameter int unsigned ATK_FRAMES    = 8,
  parameter int unsigned ATK_COOLDOWN  = 12,
  parameter int unsigned HURT_FRAMES   = 16,
  parameter int unsigned INVULN_FRAMES = 40
) (
  input logic              frame_clk,
  input logic              Reset,
  knight_action_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    RISE   = 3'd2,
    FALL   = 3'd3,
    ATTACK = 3'd4,
    HURT   = 3'd5
  } state_t;

  localparam logic [9:0] WALK_V  = 10'(WALK_SPEED);
  localparam logic [9:0] RISE_V  = 10'(RISE_SPEED);
  localparam logic [9:0] FALL_V  = 10'(FALL_SPEED);
  localparam logic [9:0] KNOCK_V = 10'(KNOCK_SPEED);
  localparam logic [5:0] MINJ_C  = 6'(MIN_JUMP - 1);
  localparam logic [5:0] MAXJ_C  = 6'(MAX_JUMP - 1);
  localparam logic [5:0] ATK_C   = 6'(ATK_FRAMES);
  localparam logic [5:0] CD_C    = 6'(ATK_COOLDOWN);
  localparam logic [5:0] HURT_C  = 6'(HURT_FRAMES);
  localparam logic [5:0] INV_C   = 6'(INVULN_FRAMES);

  state_t     state, state_n;
  logic [5:0] ctr, ctr_n, cd, cd_n, iv, iv_n;
  logic [9:0] xv, xv_n, yv, yv_n;
  logic       face, face_n, prev_jump;

  logic       key_jump, key_left, key_right, key_atk, jump_edge;
  logic       hit_ok, start_atk;
  logic [9:0] steer_v, air_y;
  logic       steer_face;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ctr       <= '0;
      cd        <= '0;
      iv        <= '0;
      xv        <= '0;
      yv        <= '0;
      face      <= 1'b0;
      prev_jump <= 1'b0;
    end else begin
      state     <= state_n;
      ctr       <= ctr_n;
      cd        <= cd_n;
      iv        <= iv_n;
      xv        <= xv_n;
      yv        <= yv_n;
      face      <= face_n;
      prev_jump <= key_jump;
    end
  end

  always_comb begin
    key_jump   = (bus.keycode == 8'h52);
    key_left   = (bus.keycode == 8'h50);
    key_right  = (bus.keycode == 8'h4F);
    key_atk    = (bus.keycode == 8'h1B);
    jump_edge  = key_jump && !prev_jump;
    hit_ok     = bus.hit && (iv == '0);
    start_atk  = key_atk && (cd == '0) &&
                 (state == IDLE || state == WALK || state == RISE || state == FALL);
    steer_v    = key_left ? (10'd0 - WALK_V) : (key_right ? WALK_V : '0);
    steer_face = key_left ? 1'b1 : (key_right ? 1'b0 : face);
    air_y      = bus.on_ground ? '0 : FALL_V;

    state_n = state;
    ctr_n   = ctr;
    cd_n    = (cd != '0) ? cd - 6'd1 : '0;
    iv_n    = (iv != '0) ? iv - 6'd1 : '0;
    xv_n    = xv;
    yv_n    = yv;
    face_n  = face;

    if (hit_ok) begin
      state_n = HURT;
      ctr_n   = HURT_C;
      iv_n    = INV_C;
      xv_n    = face ? KNOCK_V : (10'd0 - KNOCK_V);
      yv_n    = air_y;
    end else if (start_atk) begin
      state_n = ATTACK;
      ctr_n   = ATK_C;
      xv_n    = '0;
      yv_n    = air_y;
    end else begin
      unique case (state)
        IDLE, WALK: begin
          xv_n   = steer_v;
          face_n = steer_face;
          if (jump_edge && bus.on_ground) begin
            state_n = RISE;
            ctr_n   = '0;
            yv_n    = 10'd0 - RISE_V;
          end else if (!bus.on_ground) begin
            state_n = FALL;
            yv_n    = FALL_V;
          end else begin
            state_n = (key_left || key_right) ? WALK : IDLE;
            yv_n    = '0;
          end
        end
        RISE: begin
          xv_n   = steer_v;
          face_n = steer_face;
          // ctr counts rise frames already shown, so it is tested before bumping
          if (ctr >= MAXJ_C || (!key_jump && ctr >= MINJ_C)) begin
            state_n = FALL;
            yv_n    = FALL_V;
          end else begin
            ctr_n = ctr + 6'd1;
            yv_n  = 10'd0 - RISE_V;
          end
        end
        FALL: begin
          xv_n   = steer_v;
          face_n = steer_face;
          if (bus.on_ground) begin
            state_n = (key_left || key_right) ? WALK : IDLE;
            yv_n    = '0;
          end else begin
            yv_n = FALL_V;
          end
        end
        ATTACK: begin
          xv_n = '0;
          yv_n = air_y;
          if (ctr <= 6'd1) begin
            ctr_n   = '0;
            cd_n    = CD_C;
            state_n = bus.on_ground ? IDLE : FALL;
          end else begin
            ctr_n = ctr - 6'd1;
          end
        end
        HURT: begin
          yv_n = air_y;
          if (ctr <= 6'd1) begin
            ctr_n   = '0;
            xv_n    = '0;
            state_n = bus.on_ground ? IDLE : FALL;
          end else begin
            ctr_n = ctr - 6'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.x_vel         = xv;
  assign bus.y_vel         = yv;
  assign bus.status        = {1'b0, state};
  assign bus.facing        = face;
  assign bus.attack_active = (state == ATTACK);
  assign bus.invuln        = (iv != '0);

endmodule

// File: tb/tb_knight_action_ctrl.sv
// Scoreboard bench for knight_action_ctrl: a time-stamp based reference model
// predicts each frame's outputs, a monitor compares them after every edge.
module tb_knight_action_ctrl;

  localparam int WALK = 2, RISE = 6, FALL = 6, KNOCK = 3, MINJ = 4, MAXJ = 18;
  localparam int ATKF = 8, ATKCD = 12, HURTF = 16, INVF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knight_action_if bus();

  knight_action_ctrl #(
    .WALK_SPEED(WALK), .RISE_SPEED(RISE), .FALL_SPEED(FALL), .KNOCK_SPEED(KNOCK),
    .MIN_JUMP(MINJ), .MAX_JUMP(MAXJ), .ATK_FRAMES(ATKF), .ATK_COOLDOWN(ATKCD),
    .HURT_FRAMES(HURTF), .INVULN_FRAMES(INVF)
  ) dut (
    .frame_clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  typedef struct {
    int xv; int yv; int st; int face; int atk; int inv;
  } exp_t;

  typedef enum int {M_IDLE = 0, M_WALK = 1, M_RISE = 2, M_FALL = 3, M_ATK = 4, M_HURT = 5} mode_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: modes are timed from the frame they began, not counted down.
  mode_t m_mode;
  int    t, t0, atk_end, last_hit, m_xv, m_yv, m_face;
  bit    m_prevj;

  task automatic model_reset();
    m_mode = M_IDLE; m_xv = 0; m_yv = 0; m_face = 0; m_prevj = 0;
    atk_end = -1000; last_hit = -1000; t0 = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input bit og, input bit h, output exp_t e);
    bit jmp, jedge, can_hit, can_atk;
    int dir, n;
    t++;
    jmp = (k == 8'h52);
    jedge = jmp && !m_prevj;
    m_prevj = jmp;
    dir = (k == 8'h50) ? -1 : ((k == 8'h4F) ? 1 : 0);
    can_hit = h && (t - last_hit > INVF);
    can_atk = (k == 8'h1B) && (t - atk_end > ATKCD) &&
              (m_mode inside {M_IDLE, M_WALK, M_RISE, M_FALL});
    if (can_hit) begin
      m_mode = M_HURT; t0 = t; last_hit = t;
      m_xv = m_face ? KNOCK : -KNOCK;
      m_yv = og ? 0 : FALL;
    end else if (can_atk) begin
      m_mode = M_ATK; t0 = t; m_xv = 0; m_yv = og ? 0 : FALL;
    end else begin
      if (m_mode inside {M_IDLE, M_WALK, M_RISE, M_FALL}) begin
        m_xv = dir * WALK;
        if (dir < 0) m_face = 1;
        if (dir > 0) m_face = 0;
      end
      case (m_mode)
        M_IDLE, M_WALK: begin
          if (jedge && og) begin m_mode = M_RISE; t0 = t; m_yv = -RISE; end
          else if (!og) begin m_mode = M_FALL; m_yv = FALL; end
          else begin m_mode = (dir != 0) ? M_WALK : M_IDLE; m_yv = 0; end
        end
        M_RISE: begin
          n = t - t0 - 1;
          if (n >= MAXJ - 1 || (!jmp && n >= MINJ - 1)) begin m_mode = M_FALL; m_yv = FALL; end
          else m_yv = -RISE;
        end
        M_FALL: begin
          if (og) begin m_mode = (dir != 0) ? M_WALK : M_IDLE; m_yv = 0; end
          else m_yv = FALL;
        end
        M_ATK: begin
          m_xv = 0; m_yv = og ? 0 : FALL;
          if (t - t0 >= ATKF) begin atk_end = t; m_mode = og ? M_IDLE : M_FALL; end
        end
        M_HURT: begin
          m_yv = og ? 0 : FALL;
          if (t - t0 >= HURTF) begin m_xv = 0; m_mode = og ? M_IDLE : M_FALL; end
        end
        default: ;
      endcase
    end
    e.xv = m_xv; e.yv = m_yv; e.st = int'(m_mode); e.face = m_face;
    e.atk = (m_mode == M_ATK) ? 1 : 0;
    e.inv = (t - last_hit < INVF) ? 1 : 0;
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("x_vel",  int'($signed(bus.x_vel)), e.xv);
    check("y_vel",  int'($signed(bus.y_vel)), e.yv);
    check("status", int'(bus.status), e.st);
    check("facing", int'(bus.facing), e.face);
    check("attack_active", int'(bus.attack_active), e.atk);
    check("invuln", int'(bus.invuln), e.inv);
  endtask

  // Monitor: every frame edge out of reset presents one set of outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_all(e);
    end
  end

  task automatic step(input logic [7:0] k, input bit og, input bit h);
    exp_t e;
    @(negedge clk);
    bus.keycode = k; bus.on_ground = og; bus.hit = h;
    model_step(k, og, h, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{xv: 0, yv: 0, st: 0, face: 0, atk: 0, inv: 0};
    @(negedge clk);
    bus.keycode = 8'h00; bus.on_ground = 1'b1; bus.hit = 1'b0;
    rst = 1'b1;
    #1;
    check_all(z);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] key;
  bit         og;

  initial begin
    bus.keycode = 8'h00; bus.on_ground = 1'b1; bus.hit = 1'b0;
    t = 0;
    model_reset();
    do_reset();

    // ground walk right then left
    repeat (3) step(8'h4F, 1, 0);
    repeat (2) step(8'h50, 1, 0);
    step(8'h00, 1, 0);

    // held jump: full rise, fall, land, no re-jump while held
    step(8'h52, 1, 0);
    repeat (22) step(8'h52, 0, 0);
    repeat (4) step(8'h52, 1, 0);
    step(8'h00, 1, 0);

    // tapped jump: minimum rise
    step(8'h52, 1, 0);
    repeat (6) step(8'h00, 0, 0);
    step(8'h00, 1, 0);

    // held attack through cooldown into a second attack
    repeat (25) step(8'h1B, 1, 0);
    step(8'h00, 1, 0);

    // face right, then hit, hit during invulnerability, hit after it expires
    step(8'h4F, 1, 0);
    step(8'h00, 1, 1);
    for (int i = 1; i <= 45; i++) step(8'h00, 1, (i == 20 || i == 41));

    // reset while rising
    step(8'h52, 1, 0);
    repeat (3) step(8'h52, 0, 0);
    do_reset();
    repeat (3) step(8'h00, 1, 0);

    // randomized play
    key = 8'h00; og = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: key = 8'h00;
          1: key = 8'h50;
          2: key = 8'h4F;
          3: key = 8'h52;
          4: key = 8'h1B;
          default: key = 8'h04;
        endcase
      end
      if ($urandom_range(0, 3) == 0) og = ~og;
      step(key, og, ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
